// File: rtl/ddr_dfi_traffic_ctrl_mc_if.sv
// Bundle for ddr_dfi_traffic_ctrl_mc: per-channel requests, extension counts,
// CSR overrides and counter clear in; clock-gate enables, state, counts out.
interface ddr_dfi_traffic_ctrl_mc_if #(
    parameter int NUM_CH = 4,
    parameter int EXT_W  = 6,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0]       i_clk_en;
    logic [NUM_CH*EXT_W-1:0] i_pulse_ext;
    logic [NUM_CH-1:0]       i_ovr_sel;
    logic [NUM_CH-1:0]       i_ovr;
    logic                    i_cnt_clr;
    logic [NUM_CH-1:0]       o_traffic;
    logic                    o_any_traffic;
    logic [NUM_CH*2-1:0]     o_ch_state;
    logic [NUM_CH*CNT_W-1:0] o_active_cnt;

    modport master (
        output i_clk_en, i_pulse_ext, i_ovr_sel, i_ovr, i_cnt_clr,
        input  o_traffic, o_any_traffic, o_ch_state, o_active_cnt
    );

    modport slave (
        input  i_clk_en, i_pulse_ext, i_ovr_sel, i_ovr, i_cnt_clr,
        output o_traffic, o_any_traffic, o_ch_state, o_active_cnt
    );
endinterface

// File: rtl/ddr_dfi_traffic_ctrl_mc.sv
// Multi-channel DFI traffic / clock-gate enable controller with pulse extension,
// CSR override and saturating activity counters. Ports: i_clk, i_rst_n, bus (slave).
module ddr_dfi_traffic_ctrl_mc #(
    parameter int NUM_CH   = 4,
    parameter int EXT_W    = 6,
    parameter int CNT_W    = 16,
    parameter bit SYNC_OVR = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    ddr_dfi_traffic_ctrl_mc_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        EXT  = 2'b10
    } ch_state_e;

    ch_state_e             st_q  [NUM_CH];
    ch_state_e             st_d  [NUM_CH];
    logic [EXT_W-1:0]      ext_q [NUM_CH];
    logic [EXT_W-1:0]      ext_d [NUM_CH];
    logic [CNT_W-1:0]      cnt_q [NUM_CH];
    logic [NUM_CH-1:0]     fsm_traffic;
    logic [NUM_CH-1:0]     traffic;
    logic [NUM_CH-1:0]     ovr_sel_s;
    logic [NUM_CH-1:0]     ovr_s;

    // Per-channel FSM state and extension counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]  <= IDLE;
                ext_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]  <= st_d[c];
                ext_q[c] <= ext_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            st_d[c]  = st_q[c];
            ext_d[c] = ext_q[c];
            unique case (st_q[c])
                IDLE: begin
                    if (bus.i_clk_en[c]) begin
                        st_d[c] = ON;
                    end
                end
                ON: begin
                    if (!bus.i_clk_en[c]) begin
                        // Extension length is captured only here
                        if (bus.i_pulse_ext[c*EXT_W +: EXT_W] == '0) begin
                            st_d[c] = IDLE;
                        end else begin
                            st_d[c]  = EXT;
                            ext_d[c] = bus.i_pulse_ext[c*EXT_W +: EXT_W];
                        end
                    end
                end
                EXT: begin
                    if (bus.i_clk_en[c]) begin
                        st_d[c]  = ON;
                        ext_d[c] = '0;
                    end else if (ext_q[c] == EXT_W'(1)) begin
                        st_d[c]  = IDLE;
                        ext_d[c] = '0;
                    end else begin
                        ext_d[c] = ext_q[c] - EXT_W'(1);
                    end
                end
                default: begin
                    st_d[c]  = IDLE;
                    ext_d[c] = '0;
                end
            endcase
        end
    end

    // Override path: quasi-static CSRs, optionally resynchronised
    if (SYNC_OVR) begin : g_sync
        logic [NUM_CH-1:0] sel_m;
        logic [NUM_CH-1:0] ovr_m;
        logic [NUM_CH-1:0] sel_q;
        logic [NUM_CH-1:0] ovr_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sel_m <= '0;
                ovr_m <= '0;
                sel_q <= '0;
                ovr_q <= '0;
            end else begin
                sel_m <= bus.i_ovr_sel;
                ovr_m <= bus.i_ovr;
                sel_q <= sel_m;
                ovr_q <= ovr_m;
            end
        end

        assign ovr_sel_s = sel_q;
        assign ovr_s     = ovr_q;
    end else begin : g_nosync
        assign ovr_sel_s = bus.i_ovr_sel;
        assign ovr_s     = bus.i_ovr;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            fsm_traffic[c] = (st_q[c] != IDLE);
        end
    end

    assign traffic = (ovr_sel_s & ovr_s) | (~ovr_sel_s & fsm_traffic);

    // Saturating activity counters; clear wins over increment
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.i_cnt_clr) begin
                    cnt_q[c] <= '0;
                end else if (traffic[c] && (cnt_q[c] != '1)) begin
                    cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        bus.o_ch_state   = '0;
        bus.o_active_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.o_ch_state[c*2 +: 2]       = st_q[c];
            bus.o_active_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
        end
    end

    assign bus.o_traffic     = traffic;
    assign bus.o_any_traffic = |traffic;

endmodule

// File: tb/tb_ddr_dfi_traffic_ctrl_mc.sv
// Directed, table-driven bench for ddr_dfi_traffic_ctrl_mc
// (NUM_CH=4, EXT_W=6, CNT_W=4, SYNC_OVR=1).
module tb_ddr_dfi_traffic_ctrl_mc;

    localparam int NCH = 4;
    localparam int EW  = 6;
    localparam int CW  = 4;
    localparam int NV  = 26;

    typedef struct {
        logic [3:0] en;
        logic [3:0] exp_tr;
        logic [7:0] exp_st;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t vecs [NV];

    ddr_dfi_traffic_ctrl_mc_if #(.NUM_CH(NCH), .EXT_W(EW), .CNT_W(CW)) bus ();

    ddr_dfi_traffic_ctrl_mc #(
        .NUM_CH(NCH), .EXT_W(EW), .CNT_W(CW), .SYNC_OVR(1'b1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Each row: request applied before an edge, outputs expected after it.
        // ext: ch0=3, ch1=5, ch2=0, ch3=2
        vecs[0]  = '{4'b0001, 4'b0001, 8'h01};
        vecs[1]  = '{4'b0001, 4'b0001, 8'h01};
        vecs[2]  = '{4'b0001, 4'b0001, 8'h01};
        vecs[3]  = '{4'b0000, 4'b0001, 8'h02};
        vecs[4]  = '{4'b0000, 4'b0001, 8'h02};
        vecs[5]  = '{4'b0000, 4'b0001, 8'h02};
        vecs[6]  = '{4'b0000, 4'b0000, 8'h00};
        vecs[7]  = '{4'b0010, 4'b0010, 8'h04};
        vecs[8]  = '{4'b0000, 4'b0010, 8'h08};
        vecs[9]  = '{4'b0000, 4'b0010, 8'h08};
        vecs[10] = '{4'b0000, 4'b0010, 8'h08};
        vecs[11] = '{4'b0010, 4'b0010, 8'h04};
        vecs[12] = '{4'b0000, 4'b0010, 8'h08};
        vecs[13] = '{4'b0000, 4'b0010, 8'h08};
        vecs[14] = '{4'b0000, 4'b0010, 8'h08};
        vecs[15] = '{4'b0000, 4'b0010, 8'h08};
        vecs[16] = '{4'b0000, 4'b0010, 8'h08};
        vecs[17] = '{4'b0000, 4'b0000, 8'h00};
        vecs[18] = '{4'b0100, 4'b0100, 8'h10};
        vecs[19] = '{4'b0000, 4'b0000, 8'h00};
        vecs[20] = '{4'b0000, 4'b0000, 8'h00};
        vecs[21] = '{4'b1001, 4'b1001, 8'h41};
        vecs[22] = '{4'b0000, 4'b1001, 8'h82};
        vecs[23] = '{4'b0000, 4'b1001, 8'h82};
        vecs[24] = '{4'b0000, 4'b0001, 8'h02};
        vecs[25] = '{4'b0000, 4'b0000, 8'h00};

        rst_n           = 1'b0;
        bus.i_clk_en    = '0;
        bus.i_pulse_ext = {6'd2, 6'd0, 6'd5, 6'd3};
        bus.i_ovr_sel   = '0;
        bus.i_ovr       = '0;
        bus.i_cnt_clr   = 1'b0;
        step();
        step();
        check("rst_traffic", 32'(bus.o_traffic), 32'h0);
        check("rst_any", 32'(bus.o_any_traffic), 32'h0);
        check("rst_state", 32'(bus.o_ch_state), 32'h0);
        check("rst_cnt", 32'(bus.o_active_cnt), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus.i_clk_en = vecs[i].en;
            step();
            check($sformatf("vec%0d_traffic", i),
                  32'(bus.o_traffic), 32'(vecs[i].exp_tr));
            check($sformatf("vec%0d_state", i),
                  32'(bus.o_ch_state), 32'(vecs[i].exp_st));
            check($sformatf("vec%0d_any", i),
                  32'(bus.o_any_traffic), 32'(|vecs[i].exp_tr));
        end

        // Override on ch2: two-cycle synchroniser latency each way
        bus.i_ovr_sel = 4'b0100;
        bus.i_ovr     = 4'b0100;
        step();
        check("ovr_on_lat1", 32'(bus.o_traffic), 32'h0);
        step();
        check("ovr_on_lat2", 32'(bus.o_traffic), 32'h4);
        check("ovr_on_any", 32'(bus.o_any_traffic), 32'h1);
        check("ovr_on_state", 32'(bus.o_ch_state), 32'h0);
        bus.i_ovr = 4'b0000;
        step();
        check("ovr_off_lat1", 32'(bus.o_traffic), 32'h4);
        step();
        check("ovr_off_lat2", 32'(bus.o_traffic), 32'h0);
        bus.i_clk_en = 4'b0100;
        step();
        check("ovr_hide_tr", 32'(bus.o_traffic), 32'h0);
        check("ovr_hide_st", 32'(bus.o_ch_state), 32'h10);
        bus.i_ovr_sel = 4'b0000;
        step();
        check("ovr_rel_lat1", 32'(bus.o_traffic), 32'h0);
        step();
        check("ovr_rel_lat2", 32'(bus.o_traffic), 32'h4);
        bus.i_clk_en = 4'b0000;
        step();
        check("ovr_idle", 32'(bus.o_traffic), 32'h0);

        // Counter: clear, count, saturate, clear under traffic
        bus.i_cnt_clr = 1'b1;
        step();
        bus.i_cnt_clr = 1'b0;
        check("cnt_clr_all", 32'(bus.o_active_cnt), 32'h0);
        bus.i_clk_en = 4'b0010;
        for (int i = 0; i < 5; i++) step();
        check("cnt_ch1_4", 32'(bus.o_active_cnt[7:4]), 32'd4);
        for (int i = 0; i < 15; i++) step();
        check("cnt_ch1_sat", 32'(bus.o_active_cnt[7:4]), 32'd15);
        check("cnt_others", 32'({bus.o_active_cnt[15:8],
                                 bus.o_active_cnt[3:0]}), 32'h0);
        bus.i_cnt_clr = 1'b1;
        step();
        check("cnt_clr_prio", 32'(bus.o_active_cnt[7:4]), 32'd0);
        bus.i_cnt_clr = 1'b0;
        step();
        check("cnt_resume", 32'(bus.o_active_cnt[7:4]), 32'd1);
        bus.i_clk_en = 4'b0000;
        for (int i = 0; i < 7; i++) step();
        check("cnt_drain", 32'(bus.o_traffic), 32'h0);

        // Asynchronous reset while ch0 is in EXT with ext_cnt=4
        bus.i_cnt_clr = 1'b1;
        step();
        bus.i_cnt_clr = 1'b0;
        bus.i_pulse_ext[5:0] = 6'd4;
        bus.i_clk_en = 4'b0001;
        step();
        bus.i_clk_en = 4'b0000;
        step();
        check("pre_rst_state", 32'(bus.o_ch_state), 32'h2);
        check("pre_rst_cnt", 32'(bus.o_active_cnt[3:0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_traffic", 32'(bus.o_traffic), 32'h0);
        check("arst_state", 32'(bus.o_ch_state), 32'h0);
        check("arst_cnt", 32'(bus.o_active_cnt), 32'h0);
        check("arst_any", 32'(bus.o_any_traffic), 32'h0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("post_rst_idle_st", 32'(bus.o_ch_state), 32'h0);
        check("post_rst_idle_tr", 32'(bus.o_traffic), 32'h0);
        bus.i_clk_en = 4'b0001;
        step();
        bus.i_clk_en = 4'b0000;
        check("post_rst_req_tr", 32'(bus.o_traffic), 32'h1);
        check("post_rst_req_st", 32'(bus.o_ch_state), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr_dfi_traffic_ctrl_mc.md
Name: ddr_dfi_traffic_ctrl_mc

Overview:
- Parametrised, multi-channel traffic and clock-enable controller for the DFI-side PHY clock tree.
- Handles NUM_CH independent traffic classes (WRC, WRD, CK, CA, RD and others). Each channel has:
  - a per-channel state machine with pulse extension and retrigger;
  - an optional synchronised CSR override;
  - a saturating activity counter for power and utilisation monitoring.
- Outputs o_traffic[] drive the clock-gate enables of the downstream per-class clock gates.

Parameters:
- NUM_CH, 4, number of independent traffic channels (1..16).
- EXT_W, 6, width of each per-channel pulse-extension count.
- CNT_W, 16, width of each per-channel activity counter.
- SYNC_OVR, 1, 1 = override inputs pass a 2-flop synchroniser; 0 = used directly (already in i_clk domain).

Ports:
- i_clk  in  1  DFI clock; single clock for the whole block.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clk_en  in  NUM_CH  per-channel traffic request, i_clk domain.
- i_pulse_ext  in  NUM_CH*EXT_W  per-channel extension cycles; channel c uses bits [c*EXT_W +: EXT_W].
- i_ovr_sel  in  NUM_CH  per-channel override select (CSR, quasi-static).
- i_ovr  in  NUM_CH  per-channel override value.
- i_cnt_clr  in  1  synchronous clear of all activity counters.
- o_traffic  out  NUM_CH  per-channel clock-gate enable.
- o_any_traffic  out  1  OR of all o_traffic bits.
- o_ch_state  out  NUM_CH*2  per-channel FSM state (IDLE=00, ON=01, EXT=10).
- o_active_cnt  out  NUM_CH*CNT_W  per-channel saturating count of cycles with o_traffic=1.

Behaviour:
- Reset (asynchronous, any time including mid-operation) forces, independently of i_clk:
  - all FSMs to IDLE, all extension counters to 0, all activity counters to 0;
  - all synchroniser flops to 0;
  - all outputs to 0.
- Per-channel FSM, evaluated on each rising edge of i_clk:
  - IDLE: i_clk_en=1 -> ON; otherwise stay in IDLE.
  - ON: i_clk_en=1 -> stay in ON. i_clk_en=0 and ext==0 -> IDLE. i_clk_en=0 and ext!=0 -> EXT, load ext_cnt=ext.
  - EXT: i_clk_en=1 -> ON (retrigger; ext_cnt is discarded). i_clk_en=0 and ext_cnt==1 -> IDLE. Otherwise ext_cnt decrements by 1.
  - ext is sampled only on the ON->EXT transition. Changes to i_pulse_ext while in EXT are ignored until the next load.
- FSM traffic is (state != IDLE), taken from the registered state. There is no combinational path from i_clk_en.
- Timing: for a request high in cycles k..m with extension N, FSM traffic is high in cycles k+1..m+1+N, i.e. 1-cycle latency plus N extension cycles. With N=0 it is high in k+1..m+1.
- Single-cycle requests and back-to-back requests are both handled: a 1-cycle request at k gives traffic high in k+1..k+1+N.
- Override:
  - o_traffic[c] = ovr_sel_s[c] ? ovr_s[c] : fsm_traffic[c].
  - With SYNC_OVR=1, ovr_sel and ovr each pass a 2-flop synchroniser, giving 2 cycles of latency from input to effect. With SYNC_OVR=0 the effect is combinational.
  - The FSM keeps running while overridden. On override release, o_traffic resumes the current FSM value immediately, with no glitch beyond a normal mux change.
- o_any_traffic is the combinational OR of o_traffic.
- Activity counter per channel:
  - increments by 1 in each cycle o_traffic[c]=1;
  - saturates at 2^CNT_W-1 and never wraps;
  - i_cnt_clr=1 clears all counters to 0 that cycle. Clear has priority over increment.
- o_ch_state reflects the registered FSM state only; it is unaffected by override.
- Channels are fully independent. Simultaneous events on different channels do not interact.

Test Plan:
- Single request, ext=3: i_clk_en[0] high in cycles 10..12 -> o_traffic[0] high in cycles 11..16. o_ch_state[0] is ON in 11..13, EXT in 14..16, IDLE at 17.
- Retrigger, ext=5: i_clk_en[1] high at 10, low in 11..13, high at 14, then low -> o_traffic[1] is continuous from 11. State goes EXT at 12, ON at 15, then EXT and finally IDLE after 5 extension cycles.
- Zero extension, ext=0: 1-cycle request at 20 -> o_traffic high in cycle 21 only. The FSM never enters EXT.
- Override with SYNC_OVR=1: ovr_sel=1 and ovr=1 set at cycle 30 with i_clk_en=0 -> o_traffic goes high at 32. Setting ovr=0 at 40 -> o_traffic goes low at 42 while the FSM remains IDLE.
- Counter, CNT_W=4: channel held active for 20 cycles -> o_active_cnt=15 (saturated). i_cnt_clr pulsed together with active traffic -> 0 the next cycle, then increments resume.
- Reset mid-EXT: i_rst_n pulled low while a channel is in EXT with ext_cnt=4 -> o_traffic, o_ch_state and o_active_cnt read 0 before the next i_clk edge. After release, the channel stays IDLE until a new request arrives.
